// File: rtl/pid_ram_pkg.sv
// pid_ram_pkg: shared widths, RAM read latency and sequencer state encoding.
package pid_ram_pkg;
    localparam int ADDR_W_DEF = 11;
    localparam int DATA_W_DEF = 16;
    localparam int DIV_W_DEF  = 16;
    localparam int RD_LAT_DEF = 2;
    typedef logic [2:0] seq_state_t;
    localparam seq_state_t S_IDLE    = 3'd0;
    localparam seq_state_t S_READ    = 3'd1;
    localparam seq_state_t S_CAPTURE = 3'd2;
    localparam seq_state_t S_PRESENT = 3'd3;
    localparam seq_state_t S_WAIT    = 3'd4;
endpackage

// File: rtl/sample_tick_gen.sv
// sample_tick_gen: counts 0..div while enabled and flags the terminal count as a tick.
module sample_tick_gen #(
    parameter int DIV_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);
    logic [DIV_W-1:0] cnt_q, cnt_d;
    assign tick = en && cnt_q == div;
    always_comb cnt_d = (clr || tick) ? '0 : en ? cnt_q + 1'b1 : cnt_q;
    always_ff @(posedge clock or posedge reset)
        if (reset) cnt_q <= '0;
        else cnt_q <= cnt_d;
endmodule

// File: rtl/ram_sample_sequencer.sv
// ram_sample_sequencer: sweeps the input sample RAM at a programmable period and hands each word to the PID core.
// Define SEQ_LOOP_EN to wrap from last_addr back to 0 and keep sweeping until stop.
module ram_sample_sequencer
    import pid_ram_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int DIV_W  = DIV_W_DEF,
    parameter int RD_LAT = RD_LAT_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic [DIV_W-1:0]  div,
    input  logic [ADDR_W-1:0] last_addr,
    output logic [ADDR_W-1:0] ram_address,
    output logic              ram_wren,
    input  logic [DATA_W-1:0] ram_q,
    output logic [DATA_W-1:0] sample_data,
    output logic              sample_valid,
    input  logic              sample_ready,
    output logic              busy,
    output logic              done,
    output logic              overrun
);
`ifdef SEQ_LOOP_EN
    localparam logic LOOP = 1'b1;
`else
    localparam logic LOOP = 1'b0;
`endif
    localparam int WC_W = $clog2(RD_LAT + 1);
    seq_state_t state_q, state_d;
    logic [ADDR_W-1:0] ram_address_q, ram_address_d, last_addr_q, last_addr_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [DATA_W-1:0] sample_data_q, sample_data_d;
    logic [WC_W-1:0] wcnt_q, wcnt_d;
    logic sample_valid_q, sample_valid_d, busy_q, busy_d, done_q, done_d, overrun_q, overrun_d;
    logic go, tick, xfer, at_last;
    assign go      = start && !stop && state_q == S_IDLE;
    assign xfer    = sample_valid_q && sample_ready;
    assign at_last = ram_address_q == last_addr_q;
    sample_tick_gen #(.DIV_W(DIV_W)) u_tick (
        .clock (clock),
        .reset (reset),
        .clr   (go),
        .en    (busy_q),
        .div   (div_q),
        .tick  (tick)
    );
    always_comb begin
        state_d        = state_q;
        ram_address_d  = ram_address_q;
        last_addr_d    = last_addr_q;
        div_d          = div_q;
        sample_data_d  = sample_data_q;
        sample_valid_d = sample_valid_q;
        busy_d         = busy_q;
        done_d         = 1'b0;
        overrun_d      = overrun_q;
        wcnt_d         = wcnt_q;
        if (stop) begin
            state_d        = S_IDLE;
            ram_address_d  = '0;
            sample_valid_d = 1'b0;
            busy_d         = 1'b0;
        end else begin
            // a tick that cannot launch a read is dropped for good
            if (tick && (state_q == S_READ || state_q == S_CAPTURE || (state_q == S_PRESENT && !xfer)))
                overrun_d = 1'b1;
            case (state_q)
                S_IDLE: if (start) begin
                    state_d       = S_READ;
                    div_d         = div;
                    last_addr_d   = last_addr;
                    ram_address_d = '0;
                    overrun_d     = 1'b0;
                    busy_d        = 1'b1;
                end
                S_READ: begin
                    state_d = S_CAPTURE;
                    wcnt_d  = '0;
                end
                S_CAPTURE: if (wcnt_q == WC_W'(RD_LAT - 1)) begin
                    state_d        = S_PRESENT;
                    sample_data_d  = ram_q;
                    sample_valid_d = 1'b1;
                end else wcnt_d = wcnt_q + 1'b1;
                S_PRESENT: if (xfer) begin
                    sample_valid_d = 1'b0;
                    if (at_last && !LOOP) begin
                        state_d       = S_IDLE;
                        done_d        = 1'b1;
                        busy_d        = 1'b0;
                        ram_address_d = '0;
                    end else begin
                        ram_address_d = at_last ? '0 : ram_address_q + 1'b1;
                        state_d       = tick ? S_READ : S_WAIT;
                    end
                end
                S_WAIT: if (tick) state_d = S_READ;
                default: state_d = S_IDLE;
            endcase
        end
    end
    always_ff @(posedge clock or posedge reset)
        if (reset) begin
            state_q        <= S_IDLE;
            ram_address_q  <= '0;
            last_addr_q    <= '0;
            div_q          <= '0;
            sample_data_q  <= '0;
            sample_valid_q <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            overrun_q      <= 1'b0;
            wcnt_q         <= '0;
        end else begin
            state_q        <= state_d;
            ram_address_q  <= ram_address_d;
            last_addr_q    <= last_addr_d;
            div_q          <= div_d;
            sample_data_q  <= sample_data_d;
            sample_valid_q <= sample_valid_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            overrun_q      <= overrun_d;
            wcnt_q         <= wcnt_d;
        end
    assign ram_address  = ram_address_q;
    assign ram_wren     = 1'b0;
    assign sample_data  = sample_data_q;
    assign sample_valid = sample_valid_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign overrun      = overrun_q;
endmodule

// File: tb/tb_ram_sample_sequencer.sv
// tb_ram_sample_sequencer: random and directed sweeps checked against a cycle-accounting model of the sequencer.
module tb_ram_sample_sequencer;
    import pid_ram_pkg::*;
    localparam int AW = ADDR_W_DEF;
    localparam int DW = DATA_W_DEF;
    localparam int VW = DIV_W_DEF;
`ifdef SEQ_LOOP_EN
    localparam bit LOOP = 1'b1;
`else
    localparam bit LOOP = 1'b0;
`endif
    logic clock = 1'b0, reset = 1'b1, start = 1'b0, stop = 1'b0, sample_ready = 1'b0;
    logic [VW-1:0] div = '0;
    logic [AW-1:0] last_addr = '0;
    logic [AW-1:0] ram_address;
    logic ram_wren, sample_valid, busy, done, overrun;
    logic [DW-1:0] ram_q, sample_data;
    logic [DW-1:0] mem [2**AW];
    logic [AW-1:0] addr_r;
    int vectors = 0, miscompares = 0;
    logic m_busy, m_valid, m_done, m_ovr, m_pend;
    logic [AW-1:0] m_addr, m_last;
    logic [DW-1:0] m_data;
    int m_div, m_c, m_age;

    ram_sample_sequencer dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .stop         (stop),
        .div          (div),
        .last_addr    (last_addr),
        .ram_address  (ram_address),
        .ram_wren     (ram_wren),
        .ram_q        (ram_q),
        .sample_data  (sample_data),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .busy         (busy),
        .done         (done),
        .overrun      (overrun)
    );

    always #5 clock = ~clock;

    // two-stage registered RAM read path
    always @(posedge clock) begin
        addr_r <= ram_address;
        ram_q  <= mem[addr_r];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_valid = 0; m_done = 0; m_ovr = 0; m_pend = 0;
        m_addr = '0; m_last = '0; m_data = '0; m_div = 0; m_c = 0; m_age = 0;
    endtask

    task automatic check_all();
        chk("valid", sample_valid, m_valid);
        chk("busy", busy, m_busy);
        chk("done", done, m_done);
        chk("overrun", overrun, m_ovr);
        chk("addr", ram_address, m_addr);
        chk("wren", ram_wren, 0);
        if (m_valid) chk("data", sample_data, m_data);
    endtask

    // one clock edge of the reference: a sample is presented RD_LAT+1 edges after its read is issued,
    // ticks fall on every (div+1)th cycle since start, and a tick only launches a read when the path is free
    task automatic model_edge();
        bit tick, xfer;
        tick = m_busy && (m_c % (m_div + 1) == m_div);
        xfer = m_valid && sample_ready;
        m_done = 0;
        if (stop) begin
            m_busy = 0; m_valid = 0; m_pend = 0; m_addr = '0;
        end else if (!m_busy) begin
            if (start) begin
                m_busy = 1; m_addr = '0; m_ovr = 0; m_div = int'(div); m_last = last_addr;
                m_c = 0; m_pend = 1; m_age = 0;
            end
        end else begin
            m_c++;
            if (tick && m_pend && !xfer) m_ovr = 1;
            if (m_pend && !m_valid) begin
                m_age++;
                if (m_age == RD_LAT_DEF + 1) begin
                    m_valid = 1;
                    m_data = mem[m_addr];
                end
            end
            if (xfer) begin
                m_pend = 0; m_valid = 0;
                if (m_addr == m_last && !LOOP) begin
                    m_done = 1; m_busy = 0; m_addr = '0;
                end else begin
                    m_addr = (m_addr == m_last) ? '0 : m_addr + 1'b1;
                    if (tick) begin m_pend = 1; m_age = 0; end
                end
            end else if (tick && !m_pend) begin
                m_pend = 1; m_age = 0;
            end
        end
    endtask

    task automatic step(input logic st, input logic sp, input logic rdy);
        @(negedge clock);
        check_all();
        start = st; stop = sp; sample_ready = rdy;
        @(posedge clock);
        model_edge();
    endtask

    initial begin
        for (int i = 0; i < 2**AW; i++) mem[i] = DW'(16'h0010 * i + 1);
        model_reset();
        repeat (2) @(negedge clock);
        reset = 1'b0;
        step(0, 0, 0);
        // reset asserted while a read is in flight
        div = 16'd3; last_addr = 11'd3;
        step(1, 0, 1);
        step(0, 0, 1);
        @(negedge clock);
        check_all();
        reset = 1'b1;
        #1;
        chk("rst_valid", sample_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_addr", ram_address, 0);
        chk("rst_data", sample_data, 0);
        chk("rst_done", done, 0);
        chk("rst_ovr", overrun, 0);
        model_reset();
        start = 0; stop = 0; sample_ready = 0;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        step(0, 0, 1);
        step(0, 0, 1);
        // four-word sweep, period 4, consumer always ready
        step(1, 0, 1);
        repeat (24) step(0, 0, 1);
        // consumer stalls 12 clocks on the first sample
        step(1, 0, 0);
        repeat (15) step(0, 0, 0);
        repeat (24) step(0, 0, 1);
        // stop while a sample waits in PRESENT
        step(1, 0, 0);
        repeat (6) step(0, 0, 0);
        step(0, 1, 0);
        repeat (4) step(0, 0, 1);
        // fastest period over the whole address space
        div = 16'd0; last_addr = 11'h7FF;
        step(1, 0, 1);
        repeat (8210) step(0, 0, 1);
        step(0, 1, 0);
        repeat (3) step(0, 0, 0);
        for (int i = 0; i < 2**AW; i++) mem[i] = DW'($urandom);
        repeat (3) step(0, 0, 0);
        for (int r = 0; r < 40; r++) begin
            div = VW'($urandom_range(0, 6));
            last_addr = AW'($urandom_range(0, 9));
            for (int k = 0; k < 150; k++)
                step($urandom_range(0, 15) == 0, $urandom_range(0, 63) == 0, $urandom_range(0, 3) != 0);
        end
        @(negedge clock);
        check_all();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
